axis_packet_arbiter: RTL
========================

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of slave streams; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 16, tdata width per port in bits.
REQ-003 Parameter ID_WIDTH, default 2, width of m_axis_tid; SHALL be at least ceil(log2(NUM_PORTS)).
REQ-004 aclk  in  1  single clock; all logic on the rising edge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low; the block uses one clock, and reset is asynchronous and active-low.
REQ-006 s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 s_axis_tvalid  in  NUM_PORTS  per-port valid.
REQ-008 s_axis_tlast  in  NUM_PORTS  per-port end of packet.
REQ-009 s_axis_tready  out  NUM_PORTS  per-port ready.
REQ-010 m_axis_tdata  out  DATA_WIDTH  granted port data.
REQ-011 m_axis_tvalid  out  1  granted port valid.
REQ-012 m_axis_tlast  out  1  granted port last.
REQ-013 m_axis_tid  out  ID_WIDTH  index of the granted port, zero-extended.
REQ-014 m_axis_tready  in  1  downstream ready.
REQ-015 busy  out  1  high while a grant is held (state GRANT).

Function
REQ-016 FSM states: IDLE (no grant) and GRANT (one port owns the output).
REQ-017 IDLE: all s_axis_tready low; m_axis_tvalid low; m_axis_tdata, m_axis_tlast and m_axis_tid hold their last values.
REQ-018 IDLE with any s_axis_tvalid high: select the first requesting port after last_grant, scanning upward modulo NUM_PORTS; register the result as grant and last_grant; enter GRANT next cycle.
REQ-019 Arbitration latency SHALL be exactly one cycle: a request seen in IDLE at edge N appears on m_axis_tvalid in the cycle after edge N.
REQ-020 GRANT, combinational passthrough:
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast equal port grant's signals.
  - m_axis_tid equals grant.
  - s_axis_tready[grant] equals m_axis_tready; all other s_axis_tready bits are low.
REQ-021 The grant SHALL NOT change inside a packet; only a beat with m_axis_tvalid, m_axis_tready and m_axis_tlast all high ends it, and the next state is IDLE.
REQ-022 After each packet there SHALL be exactly one IDLE bubble cycle before the next grant, including when the same port is granted again.
REQ-023 Round-robin fairness: with all ports requesting continuously, grants cycle 0,1,..,NUM_PORTS-1,0; no port waits more than NUM_PORTS-1 packets.
REQ-024 A port that deasserts tvalid mid-packet keeps the grant; the block only stalls, never reorders beats.
REQ-025 Single-beat packets (tvalid and tlast on the first beat) SHALL be legal and complete in one GRANT cycle.
REQ-026 While m_axis_tvalid is high and m_axis_tready is low, the output data, last and tid SHALL stay stable (inherited from the AXI-Stream-compliant source).
REQ-027 Requests from non-granted ports arriving during GRANT are not lost; they are evaluated in the next IDLE cycle.

Reset
REQ-028 Asserting aresetn low SHALL, without waiting for a clock edge, force: state IDLE, last_grant NUM_PORTS-1 (port 0 has first priority), grant 0.
REQ-029 During reset, all s_axis_tready, m_axis_tvalid and busy SHALL be low.
REQ-030 Reset mid-packet drops the packet without completing it; after release, arbitration restarts from port 0.
REQ-031 Deassertion is synchronized externally; the first arbitration is at the first edge with aresetn high.

Verification
REQ-032 NUM_PORTS=4, only port 2 sends a 3-beat packet 0xA1,0xA2,0xA3, m_axis_tready=1 -> output shows those three beats with tid=2, tlast on 0xA3 only; busy high for 3 cycles.
REQ-033 All 4 ports continuously send 2-beat packets -> grant order is 0,1,2,3,0; one bubble cycle between packets; no beat interleaving.
REQ-034 Port 1 granted, m_axis_tready toggles 1,0,0,1 -> each beat is held stable while stalled; s_axis_tready[1] tracks m_axis_tready; other readies stay 0.
REQ-035 Port 3 sends single-beat packet 0x55 while port 0 is mid-packet -> port 3 waits; after port 0's tlast beat and one IDLE cycle, 0x55 is output with tid=3 and tlast=1.
REQ-036 aresetn pulsed low mid-packet on port 1 -> m_axis_tvalid and busy drop immediately; with ports 1 and 2 requesting after release, port 1 is granted first (priority restarts from port 0).
REQ-037 Formal: output stable while stalled; at most one s_axis_tready bit high; grant constant while busy and no tlast handshake.

Source files
------------

// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle for the packet arbiter: NUM_PORTS slave streams in, one merged stream out.
// Modport master is the arbiter's view; modport slave is the surrounding sources/sink.
interface axis_packet_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2
) ();
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic                            m_axis_tvalid;
  logic                            m_axis_tlast;
  logic [ID_WIDTH-1:0]             m_axis_tid;
  logic                            m_axis_tready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    input  m_axis_tready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    output m_axis_tready
  );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Round-robin packet arbiter: one cycle from request to grant, one IDLE bubble between packets.
// Granted port is a combinational passthrough; m_axis_tready feeds only that port's s_axis_tready.
module axis_packet_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_packet_arbiter_if.master bus,
  output logic                  busy
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_last_q, hold_last_d;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_vld;
  logic                  sel_last;

  // First requester strictly after 'last', wrapping modulo NUM_PORTS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                input logic [IDX_W-1:0]     last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      idx = (int'(last) + off) % NUM_PORTS;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
    end
  end

  assign sel_data = bus.s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_vld  = bus.s_axis_tvalid[grant_q];
  assign sel_last = bus.s_axis_tlast[grant_q];

  assign bus.m_axis_tid = ID_WIDTH'(grant_q);

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_grant_d      = last_grant_q;
    hold_data_d       = hold_data_q;
    hold_last_d       = hold_last_q;
    busy              = 1'b0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tdata  = hold_data_q;
    bus.m_axis_tlast  = hold_last_q;
    bus.s_axis_tready = '0;

    case (state_q)
      IDLE: begin
        if (|bus.s_axis_tvalid) begin
          grant_d      = rr_pick(bus.s_axis_tvalid, last_grant_q);
          last_grant_d = grant_d;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        busy                       = 1'b1;
        bus.m_axis_tvalid          = sel_vld;
        bus.m_axis_tdata           = sel_data;
        bus.m_axis_tlast           = sel_last;
        bus.s_axis_tready[grant_q] = bus.m_axis_tready;
        // Remember the last presented beat so IDLE keeps showing it.
        if (sel_vld) begin
          hold_data_d = sel_data;
          hold_last_d = sel_last;
        end
        if (sel_vld && bus.m_axis_tready && sel_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
